uart_tx_frame: RTL and testbench

- UART transmitter: serialises one parallel byte per handshake into a standard asynchronous frame: start bit, LSB-first data, optional parity, one stop bit.
- Counterpart to the UART receive path. Uses the same `prescale` clocks-per-bit convention and the same parity-enable convention as the RX edge/bit counters, so a TX→RX loopback with identical settings is bit-exact.
- Sits between the core's UART register interface and the `tx` pad.

---
 rtl/uart_tx_frame_if.sv | 12 +
 rtl/uart_tx_frame.sv | 155 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between the UART register block and the transmitter.
// The master offers a byte with in_valid/in_data. The slave accepts it with in_ready.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Each bit lasts exactly `prescale` clocks. A prescale of 0 is treated as 1.
// The configuration is latched at the handshake, so input changes mid-frame do not affect the frame.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_PRESCALE = 32,
    parameter int PRSC_WIDTH   = $clog2(MAX_PRESCALE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_frame_if.slave        bus,
    input  logic                  parity_en,
    input  logic                  parity_type,
    input  logic [PRSC_WIDTH-1:0] prescale,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity over the payload: even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                  state_r, state_s;
    logic [PRSC_WIDTH-1:0]   edge_cnt_r, edge_cnt_s;
    logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_s;
    logic [DATA_WIDTH-1:0]   data_r, data_s;
    logic                    par_en_r, par_en_s;
    logic                    par_odd_r, par_odd_s;
    logic [PRSC_WIDTH-1:0]   pm1_r, pm1_s;      // captured prescale minus one
    logic                    tx_out_r, tx_out_s;
    logic                    busy_r, busy_s;
    logic                    tx_done_r, tx_done_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic                    bit_end_s;

    assign in_ready_s   = (state_r == IDLE) && !rst;
    assign accept_s     = bus.in_valid && in_ready_s;
    assign bit_end_s    = (edge_cnt_r == pm1_r);
    assign bus.in_ready = in_ready_s;
    assign tx_out       = tx_out_r;
    assign busy         = busy_r;
    assign tx_done      = tx_done_r;

    // Next-state, counter and shadow-register logic; outputs are decoded from the next state.
    // This lets them be registered in step with the state.
    always_comb begin
        state_s    = state_r;
        edge_cnt_s = edge_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        data_s     = data_r;
        par_en_s   = par_en_r;
        par_odd_s  = par_odd_r;
        pm1_s      = pm1_r;
        tx_out_s   = 1'b1;
        busy_s     = 1'b0;
        tx_done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s    = START;
                    edge_cnt_s = {PRSC_WIDTH{1'b0}};
                    bit_cnt_s  = {BIT_W{1'b0}};
                    data_s     = bus.in_data;
                    par_en_s   = parity_en;
                    par_odd_s  = parity_type;
                    if (prescale == {PRSC_WIDTH{1'b0}}) begin
                        pm1_s = {PRSC_WIDTH{1'b0}};
                    end else begin
                        pm1_s = prescale - PRSC_WIDTH'(1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            START, DATA, PARITY, STOP: begin
                if (bit_end_s) begin
                    edge_cnt_s = {PRSC_WIDTH{1'b0}};
                    case (state_r)
                        START:  state_s = DATA;
                        DATA: begin
                            if (bit_cnt_r == BIT_W'(DATA_WIDTH - 1)) begin
                                bit_cnt_s = {BIT_W{1'b0}};
                                state_s   = par_en_r ? PARITY : STOP;
                            end else begin
                                bit_cnt_s = bit_cnt_r + BIT_W'(1);
                            end
                        end
                        PARITY: state_s = STOP;
                        STOP:   state_s = IDLE;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    edge_cnt_s = edge_cnt_r + PRSC_WIDTH'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                edge_cnt_s = {PRSC_WIDTH{1'b0}};
                bit_cnt_s  = {BIT_W{1'b0}};
            end
        endcase

        case (state_s)
            IDLE:    tx_out_s = 1'b1;
            START:   tx_out_s = 1'b0;
            DATA:    tx_out_s = data_s[bit_cnt_s];
            PARITY:  tx_out_s = parity_bit(data_s, par_odd_s);
            STOP:    tx_out_s = 1'b1;
            default: tx_out_s = 1'b1;
        endcase

        busy_s    = (state_s != IDLE);
        tx_done_s = (state_s == STOP) && (edge_cnt_s == pm1_s);
    end

    // State, counters, shadow configuration and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            edge_cnt_r <= {PRSC_WIDTH{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            data_r     <= {DATA_WIDTH{1'b0}};
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            pm1_r      <= {PRSC_WIDTH{1'b0}};
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            edge_cnt_r <= edge_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            data_r     <= data_s;
            par_en_r   <= par_en_s;
            par_odd_r  <= par_odd_s;
            pm1_r      <= pm1_s;
            tx_out_r   <= tx_out_s;
            busy_r     <= busy_s;
            tx_done_r  <= tx_done_s;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame.
// The expected line waveform of each frame is built from the framing rules as a per-cycle queue.
module tb_uart_tx_frame;
    localparam int DW   = 8;
    localparam int MAXP = 32;
    localparam int PW   = $clog2(MAXP) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          parity_en;
    logic          parity_type;
    logic [PW-1:0] prescale;
    logic          tx_out;
    logic          busy;
    logic          tx_done;

    int n_vec = 0;
    int n_bad = 0;
    logic exp_q[$];

    uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame #(.DATA_WIDTH(DW), .MAX_PRESCALE(MAXP), .PRSC_WIDTH(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .prescale    (prescale),
        .tx_out      (tx_out),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level for every clock of one frame.
    function automatic void build_frame(input logic [7:0] d, input bit pen, input bit podd,
                                        input int presc);
        int p;
        int ones;
        logic bits[$];
        p    = (presc == 0) ? 1 : presc;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) bits.push_back(((ones % 2) == 1) ^ podd);
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[k]) begin
            for (int j = 0; j < p; j++) exp_q.push_back(bits[k]);
        end
    endfunction

    // Request a frame at the current falling edge and check every cycle of it.
    // A nonzero stop_after returns early after that many cycles.
    task automatic run_frame(input logic [7:0] d, input bit pen, input bit podd, input int presc,
                             input bit noise, input int stop_after);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        parity_en    = pen;
        parity_type  = podd;
        prescale     = PW'(presc);
        #1;
        check_eq("ready_at_req", bus.in_ready, 1);
        build_frame(d, pen, podd, presc);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_eq("tx_out", tx_out, exp_q[c]);
            check_eq("busy", busy, 1);
            check_eq("tx_done", tx_done, (c == n - 1) ? 1 : 0);
            check_eq("ready_busy", bus.in_ready, 0);
            if (noise && c != n - 1) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 8'hFF;
                prescale     = PW'($urandom_range(0, MAXP));
                parity_en    = 1'($urandom_range(0, 1));
                parity_type  = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (stop_after > 0 && c + 1 == stop_after) return;
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check_eq("idle_tx", tx_out, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", tx_done, 0);
        check_eq("idle_ready", bus.in_ready, 1);
    endtask

    initial begin
        logic [7:0] d;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        parity_en    = 1'b0;
        parity_type  = 1'b0;
        prescale     = PW'(8);

        // Reset held with a pending request: nothing may start.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_tx", tx_out, 1);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", tx_done, 0);
            check_eq("rst_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        #1;
        check_eq("rel_ready", bus.in_ready, 1);
        idle_check();

        // Directed frames: 8N1 and the parity cases.
        run_frame(8'hA5, 1'b0, 1'b0, 8, 1'b0, 0); idle_check();
        run_frame(8'hA5, 1'b1, 1'b0, 4, 1'b0, 0); idle_check();
        run_frame(8'hA5, 1'b1, 1'b1, 4, 1'b0, 0); idle_check();
        run_frame(8'h07, 1'b1, 1'b0, 4, 1'b0, 0); idle_check();

        // Back-to-back with in_valid held; the first frame also sees 0xFF pulses mid-frame.
        run_frame(8'h3C, 1'b0, 1'b0, 2, 1'b1, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        @(negedge clk);
        check_eq("gap_tx", tx_out, 1);
        check_eq("gap_busy", busy, 0);
        check_eq("gap_ready", bus.in_ready, 1);
        run_frame(8'hC3, 1'b0, 1'b0, 2, 1'b0, 0); idle_check();

        // Prescale boundaries.
        run_frame(8'h96, 1'b0, 1'b0, 1, 1'b0, 0);  idle_check();
        run_frame(8'h4E, 1'b1, 1'b1, 32, 1'b0, 0); idle_check();
        run_frame(8'h81, 1'b0, 1'b0, 0, 1'b0, 0);  idle_check();

        // Random frames with mid-frame input noise.
        repeat (25) begin
            d = 8'($urandom);
            run_frame(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 12)), 1'b1, 0);
            idle_check();
        end

        // Reset during data bit 3 (cycles 17..20 at prescale 4).
        d = 8'($urandom);
        run_frame(d, 1'b0, 1'b0, 4, 1'b0, 18);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mrst_tx", tx_out, 1);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_done", tx_done, 0);
        check_eq("mrst_ready", bus.in_ready, 1);
        repeat (25) begin
            @(negedge clk);
            check_eq("mrst_quiet_done", tx_done, 0);
            check_eq("mrst_quiet_tx", tx_out, 1);
        end
        run_frame(8'hE1, 1'b1, 1'b0, 3, 1'b0, 0);
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
